// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control FSM.
package mc_pkg;

    typedef enum logic [3:0] {
        S_IF    = 4'd0,
        S_ID    = 4'd1,
        S_MADDR = 4'd2,
        S_MRD   = 4'd3,
        S_LWB   = 4'd4,
        S_MWR   = 4'd5,
        S_REX   = 4'd6,
        S_RWB   = 4'd7,
        S_IEX   = 4'd8,
        S_IWB   = 4'd9,
        S_BR    = 4'd10,
        S_JMP   = 4'd11,
        S_JAL   = 4'd12,
        S_JR    = 4'd13
    } state_t;

    // Opcodes (IR[31:26]) and the one func code the FSM itself cares about
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] FN_JR    = 6'b001000;

    // alu_op codes understood by alu_controller
    localparam logic [1:0] ALU_MTYPE = 2'b00;
    localparam logic [1:0] ALU_BTYPE = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_ANDOP = 2'b11;

    // Datapath mux selects
    localparam logic [1:0] RD_RT       = 2'd0;
    localparam logic [1:0] RD_RD       = 2'd1;
    localparam logic [1:0] RD_R31      = 2'd2;
    localparam logic [1:0] M2R_ALUOUT  = 2'd0;
    localparam logic [1:0] M2R_MDR     = 2'd1;
    localparam logic [1:0] M2R_PC      = 2'd2;
    localparam logic [1:0] ASB_REGB    = 2'd0;
    localparam logic [1:0] ASB_FOUR    = 2'd1;
    localparam logic [1:0] ASB_IMM     = 2'd2;
    localparam logic [1:0] ASB_IMM_SH2 = 2'd3;
    localparam logic [1:0] PCS_ALU     = 2'd0;
    localparam logic [1:0] PCS_ALUOUT  = 2'd1;
    localparam logic [1:0] PCS_JUMP    = 2'd2;
    localparam logic [1:0] PCS_REGA    = 2'd3;

    // Full control word produced each cycle
    typedef struct packed {
        logic       pc_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       instr_done;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = ctrl_t'({$bits(ctrl_t){1'b0}});

    // Result of decoding the instruction in ID
    typedef struct packed {
        logic   ill;
        state_t nxt;
    } dispatch_t;

    // Pick the execute state for an instruction; flag undecoded opcodes
    function automatic dispatch_t id_dispatch(input logic [5:0] opcode, input logic [5:0] func);
        dispatch_t d;
        d.ill = 1'b0;
        d.nxt = S_IF;
        case (opcode)
            OP_LW, OP_SW:     d.nxt = S_MADDR;
            OP_RTYPE: begin
                if (func == FN_JR) d.nxt = S_JR;
                else               d.nxt = S_REX;
            end
            OP_ADDI, OP_ANDI: d.nxt = S_IEX;
            OP_BEQ, OP_BNE:   d.nxt = S_BR;
            OP_J:             d.nxt = S_JMP;
            OP_JAL:           d.nxt = S_JAL;
            default: begin
                d.ill = 1'b1;
                d.nxt = S_IF;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Control bundle between the multi-cycle FSM (master) and the datapath (slave).
interface mc_controller_if;
    logic [5:0] opcode;
    logic [5:0] func;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
    logic       illegal;

    modport master (
        input  opcode, func, zero, mem_ready,
        output pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_src,
               instr_done, illegal
    );

    modport slave (
        output opcode, func, zero, mem_ready,
        input  pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_src,
               instr_done, illegal
    );
endinterface

// File: rtl/mc_controller.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback
// for the MIPS-subset datapath. Outputs are decodes of the state register;
// only pc_write, ir_write and instr_done also look at mem_ready or zero.
module mc_controller
    import mc_pkg::*;
(
    input logic          clk,
    input logic          rst,
    mc_controller_if.master bus
);

    state_t    state_r;
    logic      illegal_r;
    dispatch_t id_dec_s;
    ctrl_t     ctl_s;

    // Decode of the instruction currently held in IR
    always_comb begin
        id_dec_s = id_dispatch(bus.opcode, bus.func);
    end

    // State register and sticky illegal-instruction flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IF;
            illegal_r <= 1'b0;
        end else begin
            case (state_r)
                S_IF:    state_r <= bus.mem_ready ? S_ID : S_IF;
                S_ID: begin
                    state_r <= id_dec_s.nxt;
                    if (id_dec_s.ill) illegal_r <= 1'b1;
                end
                S_MADDR: state_r <= (bus.opcode == OP_SW) ? S_MWR : S_MRD;
                S_MRD:   state_r <= bus.mem_ready ? S_LWB : S_MRD;
                S_MWR:   state_r <= bus.mem_ready ? S_IF : S_MWR;
                S_REX:   state_r <= S_RWB;
                S_IEX:   state_r <= S_IWB;
                default: state_r <= S_IF;
            endcase
        end
    end

    // Control word for the current state; everything held low during reset
    always_comb begin
        ctl_s = CTRL_NONE;
        if (rst) begin
            ctl_s = CTRL_NONE;
        end else begin
            case (state_r)
                S_IF: begin
                    ctl_s.mem_read  = 1'b1;
                    ctl_s.alu_src_b = ASB_FOUR;
                    ctl_s.alu_op    = ALU_MTYPE;
                    ctl_s.pc_src    = PCS_ALU;
                    ctl_s.ir_write  = bus.mem_ready;
                    ctl_s.pc_write  = bus.mem_ready;
                end
                S_ID: begin
                    // Branch target is computed speculatively into ALUOut
                    ctl_s.alu_src_b = ASB_IMM_SH2;
                    ctl_s.alu_op    = ALU_MTYPE;
                end
                S_MADDR: begin
                    ctl_s.alu_src_a = 1'b1;
                    ctl_s.alu_src_b = ASB_IMM;
                    ctl_s.alu_op    = ALU_MTYPE;
                end
                S_MRD: begin
                    ctl_s.mem_read = 1'b1;
                    ctl_s.i_or_d   = 1'b1;
                end
                S_LWB: begin
                    ctl_s.reg_write  = 1'b1;
                    ctl_s.reg_dst    = RD_RT;
                    ctl_s.mem_to_reg = M2R_MDR;
                    ctl_s.instr_done = 1'b1;
                end
                S_MWR: begin
                    ctl_s.mem_write  = 1'b1;
                    ctl_s.i_or_d     = 1'b1;
                    ctl_s.instr_done = bus.mem_ready;
                end
                S_REX: begin
                    ctl_s.alu_src_a = 1'b1;
                    ctl_s.alu_src_b = ASB_REGB;
                    ctl_s.alu_op    = ALU_RTYPE;
                end
                S_RWB: begin
                    ctl_s.reg_write  = 1'b1;
                    ctl_s.reg_dst    = RD_RD;
                    ctl_s.mem_to_reg = M2R_ALUOUT;
                    ctl_s.instr_done = 1'b1;
                end
                S_IEX: begin
                    ctl_s.alu_src_a = 1'b1;
                    ctl_s.alu_src_b = ASB_IMM;
                    ctl_s.alu_op    = (bus.opcode == OP_ANDI) ? ALU_ANDOP : ALU_MTYPE;
                end
                S_IWB: begin
                    ctl_s.reg_write  = 1'b1;
                    ctl_s.reg_dst    = RD_RT;
                    ctl_s.mem_to_reg = M2R_ALUOUT;
                    ctl_s.instr_done = 1'b1;
                end
                S_BR: begin
                    ctl_s.alu_src_a  = 1'b1;
                    ctl_s.alu_src_b  = ASB_REGB;
                    ctl_s.alu_op     = ALU_BTYPE;
                    ctl_s.pc_src     = PCS_ALUOUT;
                    ctl_s.pc_write   = (bus.opcode == OP_BEQ) ? bus.zero : ~bus.zero;
                    ctl_s.instr_done = 1'b1;
                end
                S_JMP: begin
                    ctl_s.pc_src     = PCS_JUMP;
                    ctl_s.pc_write   = 1'b1;
                    ctl_s.instr_done = 1'b1;
                end
                S_JAL: begin
                    // PC already holds PC+4, which is the link value
                    ctl_s.pc_src     = PCS_JUMP;
                    ctl_s.pc_write   = 1'b1;
                    ctl_s.reg_write  = 1'b1;
                    ctl_s.reg_dst    = RD_R31;
                    ctl_s.mem_to_reg = M2R_PC;
                    ctl_s.instr_done = 1'b1;
                end
                S_JR: begin
                    ctl_s.pc_src     = PCS_REGA;
                    ctl_s.pc_write   = 1'b1;
                    ctl_s.instr_done = 1'b1;
                end
                default: ctl_s = CTRL_NONE;
            endcase
        end
    end

    assign bus.pc_write   = ctl_s.pc_write;
    assign bus.i_or_d     = ctl_s.i_or_d;
    assign bus.mem_read   = ctl_s.mem_read;
    assign bus.mem_write  = ctl_s.mem_write;
    assign bus.ir_write   = ctl_s.ir_write;
    assign bus.reg_dst    = ctl_s.reg_dst;
    assign bus.mem_to_reg = ctl_s.mem_to_reg;
    assign bus.reg_write  = ctl_s.reg_write;
    assign bus.alu_src_a  = ctl_s.alu_src_a;
    assign bus.alu_src_b  = ctl_s.alu_src_b;
    assign bus.alu_op     = ctl_s.alu_op;
    assign bus.pc_src     = ctl_s.pc_src;
    assign bus.instr_done = ctl_s.instr_done;
    assign bus.illegal    = illegal_r & ~rst;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: each instruction pushes its expected
// final-cycle control word and latency; a monitor pops on instr_done.
module tb_mc_controller;
    import mc_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mc_controller_if bus();
    mc_controller dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        string       name;
        logic [17:0] vec;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int n_tests  = 0;
    int n_fail   = 0;
    int irw_cnt  = 0;
    int done_cnt = 0;
    int lat_cnt  = 0;

    function automatic logic [17:0] mk(input logic pcw, input logic iord, input logic mr,
                                       input logic mw, input logic irw, input logic [1:0] rd,
                                       input logic [1:0] m2r, input logic rw, input logic asa,
                                       input logic [1:0] asb, input logic [1:0] aop,
                                       input logic [1:0] psrc, input logic ill);
        return {pcw, iord, mr, mw, irw, rd, m2r, rw, asa, asb, aop, psrc, ill};
    endfunction

    function automatic logic [17:0] snap();
        return {bus.pc_write, bus.i_or_d, bus.mem_read, bus.mem_write, bus.ir_write,
                bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.pc_src, bus.illegal};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: per-cycle exclusivity rules and scoreboard pop on instr_done
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                lat_cnt = 0;
            end else begin
                lat_cnt++;
                if (bus.ir_write) irw_cnt++;
                check("strobe_exclusive", {30'd0, bus.mem_read & bus.mem_write,
                                           bus.reg_write & bus.mem_write}, 32'd0);
                if (bus.instr_done) begin
                    done_cnt++;
                    if (sb_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_done: got instr_done=1 expected no completion");
                    end else begin
                        e = sb_q.pop_front();
                        check({e.name, "_ctrl"}, {14'd0, snap()}, {14'd0, e.vec});
                        check({e.name, "_latency"}, lat_cnt, e.lat);
                    end
                    lat_cnt = 0;
                end
            end
        end
    end

    // Issue one instruction starting in IF; w1 wait cycles in IF, w2 in MRD/MWR
    task automatic run(input string nm, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input int w1, input int w2,
                       input logic [17:0] vec, input int lat);
        exp_t e;
        bit   seen;
        seen   = 1'b0;
        e.name = nm;
        e.vec  = vec;
        e.lat  = lat;
        sb_q.push_back(e);
        bus.opcode = op;
        bus.func   = fn;
        bus.zero   = z;
        for (int k = 0; k < 40; k++) begin
            bus.mem_ready = ((k < w1) || (k >= w1 + 3 && k < w1 + 3 + w2)) ? 1'b0 : 1'b1;
            #2;
            if (bus.instr_done) seen = 1'b1;
            @(posedge clk);
            #1;
            if (seen) break;
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got no instr_done expected one within 40 cycles", nm);
        end
    endtask

    initial begin
        int irw0;
        logic [17:0] v_rwb, v_lwb, v_mwr, v_beq, v_bne, v_iwb, v_jmp, v_jal, v_jr;
        //           pcw   iord  mr    mw    irw   rd    m2r   rw    asa   asb   aop    psrc  ill
        v_rwb = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b1, 1'b0, 2'd0, 2'b00, 2'd0, 1'b0);
        v_lwb = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0, 2'd0, 2'b00, 2'd0, 1'b0);
        v_mwr = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 2'b00, 2'd0, 1'b0);
        v_beq = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 2'd0, 2'b01, 2'd1, 1'b0);
        v_bne = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 2'd0, 2'b01, 2'd1, 1'b0);
        v_iwb = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0, 2'b00, 2'd0, 1'b0);
        v_jmp = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 2'b00, 2'd2, 1'b0);
        v_jal = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2, 1'b1, 1'b0, 2'd0, 2'b00, 2'd2, 1'b0);
        v_jr  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 2'b00, 2'd3, 1'b0);

        rst = 1'b1;
        bus.opcode = 6'd0;
        bus.func = 6'd0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("reset_outputs_zero", {13'd0, snap(), bus.instr_done}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("if_after_reset", {28'd0, bus.mem_read, bus.i_or_d, bus.ir_write, bus.illegal}, 32'b1010);
        check("if_alu_src_b", {30'd0, bus.alu_src_b}, 32'd1);

        run("add",  OP_RTYPE, 6'b100000, 1'b0, 0, 0, v_rwb, 4);
        irw0 = irw_cnt;
        run("lw_waits", OP_LW, 6'd0, 1'b0, 2, 3, v_lwb, 10);
        check("lw_ir_write_pulses", irw_cnt - irw0, 32'd1);
        run("sw",   OP_SW,   6'd0, 1'b0, 0, 0, v_mwr, 4);
        run("beq",  OP_BEQ,  6'd0, 1'b1, 0, 0, v_beq, 3);
        run("bne",  OP_BNE,  6'd0, 1'b1, 0, 0, v_bne, 3);
        run("addi", OP_ADDI, 6'd0, 1'b0, 0, 0, v_iwb, 4);
        run("andi", OP_ANDI, 6'd0, 1'b0, 0, 0, v_iwb, 4);
        run("j",    OP_J,    6'd0, 1'b0, 0, 0, v_jmp, 3);
        run("jal",  OP_JAL,  6'd0, 1'b0, 0, 0, v_jal, 3);
        run("jr",   OP_RTYPE, FN_JR, 1'b0, 0, 0, v_jr, 3);
        run("rtype_unknown_func", OP_RTYPE, 6'b111111, 1'b0, 0, 0, v_rwb, 4);

        // Undecoded opcode: IF, ID, back to IF with illegal set and no completion
        bus.opcode = 6'b111111;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        #1;
        check("illegal_id_no_done", {31'd0, bus.instr_done}, 32'd0);
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
        #1;
        check("illegal_back_in_if", {28'd0, bus.illegal, bus.mem_read, bus.i_or_d, bus.instr_done}, 32'b1100);
        @(posedge clk);
        #1;
        check("illegal_held", {30'd0, bus.illegal, bus.mem_read}, 32'b11);
        rst = 1'b1;
        #1;
        check("rst_forces_zero", {13'd0, snap(), bus.instr_done}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.opcode = OP_SW;
        bus.mem_ready = 1'b1;
        #1;
        check("rst_clears_illegal", {31'd0, bus.illegal}, 32'd0);

        // sw stalled in MWR, then reset: no store may be issued afterwards
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
        #1;
        check("mwr_stalled", {30'd0, bus.mem_write, bus.instr_done}, 32'b10);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_in_mwr_zero", {13'd0, snap(), bus.instr_done}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        check("after_rst_no_write", {29'd0, bus.mem_write, bus.mem_read, bus.i_or_d}, 32'b010);
        run("sw_after_rst", OP_SW, 6'd0, 1'b0, 0, 0, v_mwr, 4);

        repeat (2) @(posedge clk);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        check("done_count", done_cnt, 32'd12);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
